// File: rtl/inv_shift_rows_stream_pkg.sv
// Shared AES state constants and (Inv)ShiftRows index helpers.
package inv_shift_rows_stream_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned AES_ROWS        = 4;
    localparam int unsigned AES_COLS        = 4;
    localparam int unsigned AES_IDX_W       = $clog2(AES_BLOCK_BYTES);
    localparam int unsigned AES_ROW_W       = $clog2(AES_ROWS);
    localparam int unsigned AES_COL_W       = $clog2(AES_COLS);

    // Column-major index k = 4*col + row; 2-bit column arithmetic wraps mod 4.
    function automatic logic [AES_IDX_W-1:0] shift_rows_src(input logic [AES_IDX_W-1:0] k);
        logic [AES_ROW_W-1:0] r;
        logic [AES_COL_W-1:0] c;
        r = k[AES_ROW_W-1:0];
        c = k[AES_IDX_W-1:AES_ROW_W];
        return {AES_COL_W'(c + AES_COL_W'(r)), r};
    endfunction

    function automatic logic [AES_IDX_W-1:0] inv_shift_rows_src(input logic [AES_IDX_W-1:0] k);
        logic [AES_ROW_W-1:0] r;
        logic [AES_COL_W-1:0] c;
        r = k[AES_ROW_W-1:0];
        c = k[AES_IDX_W-1:AES_ROW_W];
        return {AES_COL_W'(c - AES_COL_W'(r)), r};
    endfunction

endpackage

// File: rtl/aes_state_bank.sv
// 16-entry state register file: synchronous write, asynchronous read, synchronous clear.
module aes_state_bank
    import inv_shift_rows_stream_pkg::*;
#(
    parameter int unsigned word_size = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 we,
    input  logic [AES_IDX_W-1:0] waddr,
    input  logic [word_size-1:0] wdata,
    input  logic [AES_IDX_W-1:0] raddr,
    output logic [word_size-1:0] rdata
);

    logic [word_size-1:0] mem [AES_BLOCK_BYTES];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(AES_BLOCK_BYTES); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial InvShiftRows with ping-pong 16-byte banks and valid/ready on both sides.
module inv_shift_rows_stream
    import inv_shift_rows_stream_pkg::*;
#(
    parameter int unsigned word_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [word_size-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [word_size-1:0] out_data,
    output logic                 out_last
);

    localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(AES_BLOCK_BYTES - 1);

    logic [AES_IDX_W-1:0] wr_idx;
    logic [AES_IDX_W-1:0] rd_idx;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [1:0]           full;

    logic                 in_fire;
    logic                 out_fire;
    logic [1:0]           set_full;
    logic [1:0]           clr_full;
    logic [AES_IDX_W-1:0] raddr;
    logic [word_size-1:0] rdata0;
    logic [word_size-1:0] rdata1;

    // Handshake flags depend only on registered state.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign raddr     = inv_shift_rows_src(rd_idx);
    assign out_data  = rd_bank ? rdata1 : rdata0;

    always_comb begin
        set_full = 2'b00;
        clr_full = 2'b00;
        if (in_fire && (wr_idx == LAST_IDX)) begin
            set_full[wr_bank] = 1'b1;
        end
        if (out_fire && (rd_idx == LAST_IDX)) begin
            clr_full[rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            if (in_fire) begin
                wr_idx <= wr_idx + AES_IDX_W'(1);
                if (wr_idx == LAST_IDX) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (out_fire) begin
                rd_idx <= rd_idx + AES_IDX_W'(1);
                if (rd_idx == LAST_IDX) begin
                    rd_bank <= !rd_bank;
                end
            end
            full <= (full | set_full) & ~clr_full;
        end
    end

    aes_state_bank #(.word_size(word_size)) u_bank0 (
        .clk   (clk),
        .clr_n (rst),
        .we    (in_fire && !wr_bank),
        .waddr (wr_idx),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata0)
    );

    aes_state_bank #(.word_size(word_size)) u_bank1 (
        .clk   (clk),
        .clr_n (rst),
        .we    (in_fire && wr_bank),
        .waddr (wr_idx),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata1)
    );

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed self-checking bench for inv_shift_rows_stream.
module tb_inv_shift_rows_stream;
    import inv_shift_rows_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int checks   = 0;
    int failures = 0;

    logic [7:0] basic_in  [16];
    logic [7:0] basic_exp [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                   8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    // FIPS-197 Appendix B, round 1: after SubBytes and after ShiftRows (column-major).
    logic [7:0] fips_sub  [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                   8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    logic [7:0] fips_shr  [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                   8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    logic [7:0] rt_in     [16];
    logic [7:0] sent_q    [$];

    always #5 clk = ~clk;

    inv_shift_rows_stream #(.word_size(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent InvShiftRows index: out[4c+r] = in[4((c-r) mod 4)+r].
    function automatic int tb_src(input int k);
        int r;
        int c;
        r = k % 4;
        c = k / 4;
        return 4 * ((c - r + 4) % 4) + r;
    endfunction

    task automatic stream_and_check(input string tag, input logic [7:0] inb [16],
                                    input logic [7:0] exb [16]);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = inb[i];
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            if (i == 15) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(out_valid), 32'd1);
        for (int j = 0; j < 16; j++) begin
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"}, 32'(out_data), 32'(exb[j]));
            check({tag, "_last"}, 32'(out_last), 32'(j == 15));
            tick();
        end
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    // Concurrent producer/consumer with probabilities pv/pr (percent).
    task automatic run(input string tag, input int nblk, input int pv, input int pr,
                       input bit incr_data, input bit want_ready,
                       output int first_cyc, output int last_cyc);
        int sent  = 0;
        int recv  = 0;
        int cyc   = 0;
        int total = nblk * 16;
        logic [7:0] d;
        first_cyc = -1;
        last_cyc  = -1;
        sent_q.delete();
        while (recv < total && cyc < 20000) begin
            d         = incr_data ? 8'(sent) : 8'($urandom);
            in_valid  = (sent < total) && ($urandom_range(99) < pv);
            in_data   = d;
            out_ready = ($urandom_range(99) < pr);
            if (want_ready && sent < total) check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            if (in_valid && in_ready) begin
                sent_q.push_back(d);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                check({tag, "_data"}, 32'(out_data),
                      32'(sent_q[(recv / 16) * 16 + tb_src(recv % 16)]));
                check({tag, "_last"}, 32'(out_last), 32'((recv % 16) == 15));
                recv++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_count"}, 32'(recv), 32'(total));
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int f;
        int l;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) basic_in[i] = 8'(i);
        tick();
        tick();
        rst = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);

        stream_and_check("basic", basic_in, basic_exp);

        for (int i = 0; i < 16; i++) begin
            rt_in[i] = fips_sub[shift_rows_src(4'(i))];
            check("fips_shiftrows_ref", 32'(rt_in[i]), 32'(fips_shr[i]));
        end
        stream_and_check("roundtrip", rt_in, fips_sub);

        run("b2b", 4, 100, 100, 1'b1, 1'b1, f, l);
        check("b2b_first_cycle", 32'(f), 32'd16);
        check("b2b_span", 32'(l - f), 32'd63);

        // Backpressure: fill both banks with out_ready low.
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            check("bp_fill_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_data = 8'hAA;
        for (int s = 0; s < 3; s++) begin
            check("bp_full_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h40);
            check("bp_hold_last", 32'(out_last), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check("bp_ready_low", 32'(in_ready), 32'd0);
            check("bp_b0_data", 32'(out_data), 32'(8'h40 + tb_src(j)));
            tick();
        end
        check("bp_ready_back", 32'(in_ready), 32'd1);
        for (int j = 0; j < 16; j++) begin
            check("bp_b1_valid", 32'(out_valid), 32'd1);
            check("bp_b1_data", 32'(out_data), 32'(8'h50 + tb_src(j)));
            check("bp_b1_last", 32'(out_last), 32'(j == 15));
            tick();
        end
        check("bp_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        run("rand", 100, 50, 50, 1'b0, 1'b0, f, l);

        // Reset mid-operation: block 0 half read while block 1 partially written.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            in_valid  = (c < 7);
            in_data   = 8'(8'h90 + c);
            out_ready = 1'b1;
            check("mid_data", 32'(out_data), 32'(8'h80 + tb_src(c)));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_data", 32'(out_data), 32'h00);
        check("mid_rst_last", 32'(out_last), 32'd0);
        stream_and_check("post_rst", basic_in, basic_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
